// File: rtl/muli_share_arbiter.sv
// muli_share_arbiter
//   Shares one pipelined multiplier (a/b/ce/p, fixed LATENCY) among NUM_REQ
//   dataflow requesters. A round-robin arbiter issues at most one operand
//   pair per cycle. A tag pipe tracks which requester owns each in-flight
//   product, and each product is steered into that requester's one-entry
//   output buffer.
//
// Parameters
//   NUM_REQ   number of requesters (>= 2)
//   DATA_TYPE operand / result width
//   LATENCY   multiplier latency in ce-qualified edges (>= 1)
//
// Ports
//   clk, rst                      rising-edge clock; asynchronous active-low reset
//   req_lhs / req_rhs             per-requester operands, requester i in slice i
//   req_lhs_valid / req_rhs_valid per-requester operand valids (joined)
//   req_lhs_ready / req_rhs_ready per-requester accept (identical)
//   res_data / res_valid          per-requester product buffer
//   res_ready                     per-requester result accept
//   mul_a, mul_b, mul_ce          to the shared multiplier
//   mul_p                         product from the shared multiplier
//
// Optional feature (define MULI_SHARE_PERF_EN)
//   stall_cycles  cycles with mul_ce low while any product is in flight
//   issue_count   per-requester 16-bit issue counters
//   Both counters saturate at all-ones.
module muli_share_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int DATA_TYPE = 32,
    parameter int LATENCY   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ*DATA_TYPE-1:0] req_lhs,
    input  logic [NUM_REQ-1:0]           req_lhs_valid,
    input  logic [NUM_REQ*DATA_TYPE-1:0] req_rhs,
    input  logic [NUM_REQ-1:0]           req_rhs_valid,
    output logic [NUM_REQ-1:0]           req_lhs_ready,
    output logic [NUM_REQ-1:0]           req_rhs_ready,
    output logic [NUM_REQ*DATA_TYPE-1:0] res_data,
    output logic [NUM_REQ-1:0]           res_valid,
    input  logic [NUM_REQ-1:0]           res_ready,
    output logic [DATA_TYPE-1:0]         mul_a,
    output logic [DATA_TYPE-1:0]         mul_b,
    output logic                         mul_ce,
    input  logic [DATA_TYPE-1:0]         mul_p
`ifdef MULI_SHARE_PERF_EN
    ,
    output logic [31:0]                  stall_cycles,
    output logic [NUM_REQ*16-1:0]        issue_count
`endif
);

    localparam int unsigned NR    = NUM_REQ;
    localparam int          IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]                req;
    logic [NUM_REQ-1:0]                grant;
    logic                              have_grant;
    logic [IDX_W-1:0]                  gidx;
    logic [IDX_W-1:0]                  ptr_q;
    logic                              issue;
    logic                              capture;

    logic                              tag_v   [LATENCY];
    logic [IDX_W-1:0]                  tag_idx [LATENCY];
    logic                              last_v;
    logic [IDX_W-1:0]                  last_idx;

    logic [NUM_REQ-1:0]                full_q;
    logic [NUM_REQ-1:0][DATA_TYPE-1:0] data_q;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned      off);
        return IDX_W'((32'(base) + off) % NR);
    endfunction

    // A requester only competes once both operands are present.
    assign req = req_lhs_valid & req_rhs_valid;

    // Round-robin: first requester at or after ptr, wrapping.
    always_comb begin
        have_grant = 1'b0;
        gidx       = '0;
        grant      = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            if (!have_grant && req[wrap_add(ptr_q, k)]) begin
                have_grant = 1'b1;
                gidx       = wrap_add(ptr_q, k);
            end
        end
        if (have_grant) grant[gidx] = 1'b1;
    end

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (grant[i]) begin
                mul_a = req_lhs[i*DATA_TYPE +: DATA_TYPE];
                mul_b = req_rhs[i*DATA_TYPE +: DATA_TYPE];
            end
        end
    end

    assign last_v   = tag_v[LATENCY-1];
    assign last_idx = tag_idx[LATENCY-1];

    // Stall only when the product leaving the pipe has nowhere to go.
    // Tag valids clear asynchronously, so mul_ce reads 1 throughout reset.
    assign mul_ce  = ~last_v | ~full_q[last_idx] | res_ready[last_idx];
    assign issue   = have_grant & mul_ce & rst;
    assign capture = mul_ce & last_v;

    assign req_lhs_ready = grant & {NUM_REQ{mul_ce & rst}};
    assign req_rhs_ready = req_lhs_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (issue) begin
            ptr_q <= (gidx == IDX_W'(NR - 1)) ? '0 : gidx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < LATENCY; k++) begin
                tag_v[k]   <= 1'b0;
                tag_idx[k] <= '0;
            end
        end else if (mul_ce) begin
            tag_v[0]   <= issue;
            tag_idx[0] <= gidx;
            for (int unsigned k = 1; k < LATENCY; k++) begin
                tag_v[k]   <= tag_v[k-1];
                tag_idx[k] <= tag_idx[k-1];
            end
        end
    end

    // A capture wins over a same-edge drain, so a buffer can refill while
    // being read without a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= '0;
            data_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NR; i++) begin
                if (capture && last_idx == IDX_W'(i)) begin
                    full_q[i] <= 1'b1;
                    data_q[i] <= mul_p;
                end else if (res_ready[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end

    assign res_valid = full_q;
    assign res_data  = data_q;

`ifdef MULI_SHARE_PERF_EN
    logic                       any_tag_v;
    logic [31:0]                stall_q;
    logic [NUM_REQ-1:0][15:0]   icnt_q;

    always_comb begin
        any_tag_v = 1'b0;
        for (int unsigned k = 0; k < LATENCY; k++) any_tag_v = any_tag_v | tag_v[k];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            icnt_q  <= '0;
        end else begin
            if (!mul_ce && any_tag_v && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (issue && icnt_q[gidx] != '1) icnt_q[gidx] <= icnt_q[gidx] + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
    assign issue_count  = icnt_q;
`endif

endmodule

// File: tb/tb_muli_share_arbiter.sv
module tb_muli_share_arbiter;

    localparam int NR  = 2;
    localparam int DW  = 32;
    localparam int LAT = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NR*DW-1:0]    req_lhs;
    logic [NR-1:0]       req_lhs_valid;
    logic [NR*DW-1:0]    req_rhs;
    logic [NR-1:0]       req_rhs_valid;
    logic [NR-1:0]       req_lhs_ready;
    logic [NR-1:0]       req_rhs_ready;
    logic [NR*DW-1:0]    res_data;
    logic [NR-1:0]       res_valid;
    logic [NR-1:0]       res_ready;
    logic [DW-1:0]       mul_a;
    logic [DW-1:0]       mul_b;
    logic                mul_ce;
    logic [DW-1:0]       mul_p;
`ifdef MULI_SHARE_PERF_EN
    logic [31:0]         stall_cycles;
    logic [NR*16-1:0]    issue_count;
`endif

    muli_share_arbiter #(.NUM_REQ(NR), .DATA_TYPE(DW), .LATENCY(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_lhs       (req_lhs),
        .req_lhs_valid (req_lhs_valid),
        .req_rhs       (req_rhs),
        .req_rhs_valid (req_rhs_valid),
        .req_lhs_ready (req_lhs_ready),
        .req_rhs_ready (req_rhs_ready),
        .res_data      (res_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_ce        (mul_ce),
        .mul_p         (mul_p)
`ifdef MULI_SHARE_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .issue_count   (issue_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural pipelined multiplier advancing only on mul_ce.
    logic [DW-1:0] mp [LAT];
    initial for (int k = 0; k < LAT; k++) mp[k] = '0;
    always @(posedge clk) begin
        if (mul_ce) begin
            mp[0] <= mul_a * mul_b;
            for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
        end
    end
    assign mul_p = mp[LAT-1];

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          pending = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          grant_log[$];
    int          pc0[$];
    int          pc1[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Scoreboard monitor: pops an expected product whenever a result transfers.
    always @(negedge clk) begin
        if (rst) begin
            if (res_valid[0] && res_ready[0]) begin
                pc0.push_back(cyc);
                if (q0.size() == 0) fail_now("res_data0_unexpected");
                else check("res_data0", res_data[31:0], q0.pop_front());
            end
            if (res_valid[1] && res_ready[1]) begin
                pc1.push_back(cyc);
                if (q1.size() == 0) fail_now("res_data1_unexpected");
                else check("res_data1", res_data[63:32], q1.pop_front());
            end
        end
    end

    // Present one operand pair on requester i; on acceptance queue its product.
    task automatic send(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p);
        bit done = 1'b0;
        pending++;
        req_lhs[i*DW +: DW] = a;
        req_rhs[i*DW +: DW] = b;
        req_lhs_valid[i] = 1'b1;
        req_rhs_valid[i] = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (req_lhs_ready[i] && req_rhs_ready[i]) begin
                if (i == 0) q0.push_back(p);
                else        q1.push_back(p);
                grant_log.push_back(i);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        req_lhs_valid[i] = 1'b0;
        req_rhs_valid[i] = 1'b0;
        if (!done) fail_now("send_timeout");
        pending--;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (pending == 0 && q0.size() == 0 && q1.size() == 0) ok = 1'b1;
        end
        if (!ok) fail_now("drain_timeout");
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        req_lhs = '0; req_rhs = '0;
        req_lhs_valid = '0; req_rhs_valid = '0;
        res_ready = '1;

        // Reset state, with requests present to prove ready is forced low
        repeat (2) @(posedge clk); #1;
        req_lhs_valid = 2'b11; req_rhs_valid = 2'b11;
        @(negedge clk);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_lhs_ready", 32'(req_lhs_ready), 32'd0);
        check("rst_rhs_ready", 32'(req_rhs_ready), 32'd0);
        check("rst_mul_ce", 32'(mul_ce), 32'd1);
        @(posedge clk); #1;
        req_lhs_valid = '0; req_rhs_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;

        // Single issue: ready in cycle 0, result valid in cycle 5
        fork send(0, 32'd3, 32'd7, 32'd21); join_none
        @(negedge clk);
        check("t1_ready_cycle0", 32'(req_lhs_ready), 32'd1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check("t1_latency", 32'(res_valid[0]), (c == 5) ? 32'd1 : 32'd0);
        end
        drain();

        // Both requesters streaming: ptr is 1 after the r0 issue above
        grant_log.delete(); pc0.delete(); pc1.delete();
        fork
            begin
                send(0, 32'd2, 32'd3, 32'd6);   send(0, 32'd4, 32'd5, 32'd20);
                send(0, 32'd6, 32'd7, 32'd42);  send(0, 32'd8, 32'd9, 32'd72);
            end
            begin
                send(1, 32'd5, 32'd2, 32'd10);  send(1, 32'd10, 32'd3, 32'd30);
                send(1, 32'd15, 32'd4, 32'd60); send(1, 32'd20, 32'd5, 32'd100);
            end
        join
        drain();
        check("t2_grant_count", 32'(grant_log.size()), 32'd8);
        if (grant_log.size() == 8)
            for (int k = 0; k < 8; k++)
                check("t2_grant_order", 32'(grant_log[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
        check("t2_pop_count", 32'(pc0.size() + pc1.size()), 32'd8);
        if (pc0.size() == 4 && pc1.size() == 4)
            for (int k = 1; k < 4; k++) begin
                check("t2_r0_spacing", 32'(pc0[k] - pc0[k-1]), 32'd2);
                check("t2_r1_spacing", 32'(pc1[k] - pc1[k-1]), 32'd2);
            end

        // Head-of-line stall on requester 1
        res_ready = 2'b01;
        send(1, 32'd7, 32'd6, 32'd42);
        send(1, 32'd9, 32'd9, 32'd81);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("t3_stall_ce", 32'(mul_ce), 32'd0);
        check("t3_stall_valid", 32'(res_valid), 32'd2);
        check("t3_stall_data", res_data[63:32], 32'd42);
        @(posedge clk); #1;
        fork send(0, 32'd11, 32'd11, 32'd121); join_none
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t3_frozen_ce", 32'(mul_ce), 32'd0);
            check("t3_frozen_lhs_ready", 32'(req_lhs_ready), 32'd0);
            check("t3_frozen_rhs_ready", 32'(req_rhs_ready), 32'd0);
            check("t3_frozen_data", res_data[63:32], 32'd42);
        end
        @(posedge clk); #1;
        res_ready = 2'b11;
        drain();

        // Wrap-around products
        fork
            begin
                send(0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
                send(0, 32'h8000_0001, 32'd3, 32'h8000_0003);
            end
            send(1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        join
        drain();

        // Reset mid-stream: two results buffered, one stalled in flight
        res_ready = 2'b00;
        send(0, 32'd5, 32'd5, 32'd25);
        send(1, 32'd6, 32'd6, 32'd36);
        send(0, 32'd7, 32'd7, 32'd49);
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_pre_valid", 32'(res_valid), 32'd3);
        check("t5_pre_ce", 32'(mul_ce), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t5_rst_valid", 32'(res_valid), 32'd0);
        check("t5_rst_ready", 32'(req_lhs_ready), 32'd0);
        check("t5_rst_ce", 32'(mul_ce), 32'd1);
        q0.delete(); q1.delete();
        repeat (2) @(posedge clk);
        #1;
        res_ready = 2'b11;
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("t5_no_stale", 32'(res_valid), 32'd0);
        end
        @(posedge clk); #1;
        grant_log.delete();
        fork
            send(0, 32'd12, 32'd12, 32'd144);
            send(1, 32'd13, 32'd13, 32'd169);
        join
        drain();
        check("t5_ptr_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check("t5_ptr_first", 32'(grant_log[0]), 32'd0);
            check("t5_ptr_second", 32'(grant_log[1]), 32'd1);
        end

        // Operands join: a single valid operand is never granted
        req_lhs_valid = 2'b10; req_rhs_valid = 2'b00;
        @(negedge clk);
        check("join_lhs_only", 32'(req_lhs_ready), 32'd0);
        @(posedge clk); #1;
        req_lhs_valid = 2'b01; req_rhs_valid = 2'b10;
        @(negedge clk);
        check("join_split", 32'(req_rhs_ready), 32'd0);
        @(posedge clk); #1;
        req_lhs_valid = '0; req_rhs_valid = '0;
        repeat (8) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
